// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia iteration controller and its
// fixed-point datapath (signed Q11.11).
package julia_pkg;

    localparam int WIDTH      = 22;
    localparam int FRACTIONAL = 11;
    localparam int INTEGRAL   = 11;
    localparam int TAG_W      = 20;
    localparam int CNT_W      = 8;

    typedef logic signed [WIDTH-1:0]   fixed_t;
    typedef logic signed [2*WIDTH-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } iter_state_t;

    // Escape threshold on |z|^2: 4.0 in Q11.11.
    localparam fixed_t THRESH = 22'h002000;

    // Fixed-point multiply: full-width signed product, arithmetic shift back
    // to the binary point, then wrap to WIDTH bits (no saturation).
    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
        wide_t w_prod;
        w_prod = wide_t'(a) * wide_t'(b);
        return fixed_t'(w_prod >>> FRACTIONAL);
    endfunction

endpackage

// File: rtl/z_calculator.sv
// Combinational Julia step: z_next = z^2 + c, plus |z_next|^2.
// All arithmetic wraps at WIDTH bits.
module z_calculator
    import julia_pkg::*;
(
    input  logic signed [WIDTH-1:0] z_real_in,
    input  logic signed [WIDTH-1:0] z_imag_in,
    input  logic signed [WIDTH-1:0] c_real_in,
    input  logic signed [WIDTH-1:0] c_imag_in,
    input  logic [CNT_W-1:0]        iteration_in,
    output logic signed [WIDTH-1:0] z_real_out,
    output logic signed [WIDTH-1:0] z_imag_out,
    output logic signed [WIDTH-1:0] size_sq,
    output logic [CNT_W-1:0]        iteration_out
);

    logic signed [WIDTH-1:0] w_re_sq;
    logic signed [WIDTH-1:0] w_im_sq;
    logic signed [WIDTH-1:0] w_cross;

    assign w_re_sq = fx_mul(z_real_in, z_real_in);
    assign w_im_sq = fx_mul(z_imag_in, z_imag_in);
    assign w_cross = fx_mul(z_real_in, z_imag_in);

    assign z_real_out    = w_re_sq - w_im_sq + c_real_in;
    assign z_imag_out    = (w_cross <<< 1) + c_imag_in;
    assign size_sq       = fx_mul(z_real_out, z_real_out) + fx_mul(z_imag_out, z_imag_out);
    assign iteration_out = iteration_in + 8'd1;

endmodule

// File: rtl/julia_iteration_controller.sv
// Runs one Julia pixel job through z_calculator, one iteration per clock,
// and reports the iteration count plus whether the orbit escaped.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; res_valid is high only in
// DONE, and the result outputs are stable for as long as res_valid is high.
module julia_iteration_controller
    import julia_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] z0_real,
    input  logic signed [WIDTH-1:0] z0_imag,
    input  logic signed [WIDTH-1:0] c_real,
    input  logic signed [WIDTH-1:0] c_imag,
    input  logic [CNT_W-1:0]        max_iter,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CNT_W-1:0]        res_iter,
    output logic                    res_escaped,
    output logic [TAG_W-1:0]        tag_out,
    output logic [1:0]              o_dbg_state
);

    iter_state_t        r_state;
    fixed_t             r_z_real;
    fixed_t             r_z_imag;
    fixed_t             r_c_real;
    fixed_t             r_c_imag;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_limit;
    logic [TAG_W-1:0]   r_job_tag;
    logic [TAG_W-1:0]   r_tag_out;
    logic [CNT_W-1:0]   r_res_iter;
    logic               r_res_escaped;
    logic               r_in_ready;
    logic               r_res_valid;

    fixed_t             w_z_real_next;
    fixed_t             w_z_imag_next;
    fixed_t             w_size_sq;
    logic [CNT_W-1:0]   w_unused_iter;
    logic [CNT_W-1:0]   w_cnt_n;
    logic               w_escape;
    logic               w_limit_hit;

    // The datapath's own iteration counter is not used; the controller owns the count.
    z_calculator u_z_calc (
        .z_real_in     (r_z_real),
        .z_imag_in     (r_z_imag),
        .c_real_in     (r_c_real),
        .c_imag_in     (r_c_imag),
        .iteration_in  (8'd0),
        .z_real_out    (w_z_real_next),
        .z_imag_out    (w_z_imag_next),
        .size_sq       (w_size_sq),
        .iteration_out (w_unused_iter)
    );

    // Next count and termination conditions; a negative |z|^2 means the
    // squares wrapped, which can only happen for a huge orbit, so it escapes.
    always_comb begin
        w_cnt_n     = r_cnt + 8'd1;
        w_escape    = (w_size_sq >= THRESH) || w_size_sq[WIDTH-1];
        w_limit_hit = (w_cnt_n == r_limit);
    end

    // FSM, job registers, counter and registered result outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_z_real      <= '0;
            r_z_imag      <= '0;
            r_c_real      <= '0;
            r_c_imag      <= '0;
            r_cnt         <= '0;
            r_limit       <= '0;
            r_job_tag     <= '0;
            r_tag_out     <= '0;
            r_res_iter    <= '0;
            r_res_escaped <= 1'b0;
            r_in_ready    <= 1'b1;
            r_res_valid   <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_z_real   <= z0_real;
                        r_z_imag   <= z0_imag;
                        r_c_real   <= c_real;
                        r_c_imag   <= c_imag;
                        r_limit    <= max_iter;
                        r_job_tag  <= tag_in;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (max_iter == 8'd0) begin
                            r_state       <= DONE;
                            r_res_iter    <= '0;
                            r_res_escaped <= 1'b0;
                            r_tag_out     <= tag_in;
                            r_res_valid   <= 1'b1;
                        end else begin
                            r_state <= ITER;
                        end
                    end
                end
                ITER: begin
                    r_z_real <= w_z_real_next;
                    r_z_imag <= w_z_imag_next;
                    r_cnt    <= w_cnt_n;
                    if (w_escape || w_limit_hit) begin
                        r_state       <= DONE;
                        r_res_iter    <= w_cnt_n;
                        r_res_escaped <= w_escape;
                        r_tag_out     <= r_job_tag;
                        r_res_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign res_valid   = r_res_valid;
    assign res_iter    = r_res_iter;
    assign res_escaped = r_res_escaped;
    assign tag_out     = r_tag_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_julia_iteration_controller.sv
// Scoreboard bench for julia_iteration_controller: directed jobs with
// hand-computed results, a monitor that pops expectations on each result
// handshake, plus backpressure, clear and mid-job reset scenarios.
module tb_julia_iteration_controller;
    import julia_pkg::*;

    // Expected entry: {latency, iter, escaped, tag}
    localparam int EXP_W = 8 + 8 + 1 + TAG_W;

    localparam fixed_t Q_ZERO = 22'h000000;
    localparam fixed_t Q_ONE  = 22'h000800;
    localparam fixed_t Q_TWO  = 22'h001000;
    localparam fixed_t Q_NEG1 = 22'h3FF800;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             n_rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    fixed_t           z0_real, z0_imag, c_real, c_imag;
    logic [7:0]       max_iter;
    logic [TAG_W-1:0] tag_in;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_iter;
    logic             res_escaped;
    logic [TAG_W-1:0] tag_out;
    logic [1:0]       dbg_state;

    julia_iteration_controller dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .z0_real     (z0_real),
        .z0_imag     (z0_imag),
        .c_real      (c_real),
        .c_imag      (c_imag),
        .max_iter    (max_iter),
        .tag_in      (tag_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_iter    (res_iter),
        .res_escaped (res_escaped),
        .tag_out     (tag_out),
        .o_dbg_state (dbg_state)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] e;
    int               checks = 0;
    int               errors = 0;
    int unsigned      accept_cyc = 0;
    int unsigned      lat_seen = 0;
    logic             prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: measure latency on res_valid rise, compare on each handshake.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_valid = 1'b0;
        end else begin
            if (res_valid && !prev_valid) lat_seen = cyc - accept_cyc;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got iter %0d tag %0h, expected no result", res_iter, tag_out);
                end else begin
                    e = exp_q.pop_front();
                    check("res_iter",    64'(res_iter),    64'(e[TAG_W+8:TAG_W+1]));
                    check("res_escaped", 64'(res_escaped), 64'(e[TAG_W]));
                    check("tag_out",     64'(tag_out),     64'(e[TAG_W-1:0]));
                    check("latency",     64'(lat_seen),    64'(e[TAG_W+16:TAG_W+9]));
                    check("in_ready_in_done", 64'(in_ready), 64'd0);
                end
            end
            prev_valid = res_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_job(input fixed_t zr, input fixed_t zi, input fixed_t cr, input fixed_t ci,
                            input logic [7:0] mi, input logic [TAG_W-1:0] tg,
                            input bit push, input logic [7:0] x_iter, input logic x_esc);
        int n;
        logic [7:0] x_lat;
        z0_real  = zr;
        z0_imag  = zi;
        c_real   = cr;
        c_imag   = ci;
        max_iter = mi;
        tag_in   = tg;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 600 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid   = 1'b0;
        x_lat      = (mi == 8'd0) ? 8'd0 : x_iter;
        if (push) exp_q.push_back({x_lat, x_iter, x_esc, tg});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && in_ready) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!(exp_q.size() == 0 && in_ready)) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: %0d results outstanding, expected 0 within 600 cycles", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic watch_no_result(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check(name, 64'(seen), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        z0_real   = '0;
        z0_imag   = '0;
        c_real    = '0;
        c_imag    = '0;
        max_iter  = '0;
        tag_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_res_valid",   64'(res_valid),   64'd0);
        check("rst_res_iter",    64'(res_iter),    64'd0);
        check("rst_res_escaped", 64'(res_escaped), 64'd0);
        check("rst_tag_out",     64'(tag_out),     64'd0);
        check("rst_state",       64'(dbg_state),   64'(IDLE));
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed jobs: z0, c, max_iter, tag -> iter, escaped
        send_job(Q_ZERO, Q_ZERO, Q_ZERO, Q_ZERO, 8'd10,  20'h00011, 1, 8'd10,  1'b0); wait_idle();
        send_job(Q_TWO,  Q_ZERO, Q_ZERO, Q_ZERO, 8'd50,  20'h00022, 1, 8'd1,   1'b1); wait_idle();
        send_job(Q_ZERO, Q_ZERO, Q_NEG1, Q_ZERO, 8'd255, 20'hABCDE, 1, 8'd255, 1'b0); wait_idle();
        send_job(Q_TWO,  Q_ZERO, Q_ZERO, Q_ZERO, 8'd0,   20'hFFFFF, 1, 8'd0,   1'b0); wait_idle();
        send_job(Q_TWO,  Q_ZERO, Q_ZERO, Q_ZERO, 8'd1,   20'h00055, 1, 8'd1,   1'b1); wait_idle();
        send_job(Q_ZERO, Q_ZERO, Q_ONE,  Q_ZERO, 8'd30,  20'h00066, 1, 8'd2,   1'b1); wait_idle();
        send_job(Q_ZERO, Q_ZERO, Q_ZERO, Q_ONE,  8'd20,  20'h00077, 1, 8'd20,  1'b0); wait_idle();
        send_job(Q_ZERO, Q_ZERO, Q_ZERO, Q_ZERO, 8'd1,   20'h00088, 1, 8'd1,   1'b0); wait_idle();
        send_job(Q_ZERO, Q_ZERO, Q_ONE,  Q_ZERO, 8'd2,   20'h00099, 1, 8'd2,   1'b1); wait_idle();

        // Backpressure: result held in DONE while res_ready is low.
        res_ready = 1'b0;
        send_job(Q_ZERO, Q_ZERO, Q_ZERO, Q_ZERO, 8'd3, 20'h0BEEF, 1, 8'd3, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_res_valid_rise", 64'(res_valid), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid",   64'(res_valid),   64'd1);
            check("bp_in_ready",    64'(in_ready),    64'd0);
            check("bp_res_iter",    64'(res_iter),    64'd3);
            check("bp_res_escaped", 64'(res_escaped), 64'd0);
            check("bp_tag_out",     64'(tag_out),     64'h0BEEF);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        check("bp_release_res_valid", 64'(res_valid), 64'd0);
        check("bp_queue_drained",     64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // clear in ITER drops the job.
        send_job(Q_ZERO, Q_ZERO, Q_ZERO, Q_ZERO, 8'd10, 20'h0C1EA, 0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("clr_state_iter", 64'(dbg_state), 64'(ITER));
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_state",     64'(dbg_state), 64'(IDLE));
        check("clr_in_ready",  64'(in_ready),  64'd1);
        check("clr_res_valid", 64'(res_valid), 64'd0);
        watch_no_result("clr_no_result", 15);
        send_job(Q_ZERO, Q_ZERO, Q_ONE, Q_ZERO, 8'd30, 20'h00123, 1, 8'd2, 1'b1); wait_idle();

        // Asynchronous reset mid-job returns everything to reset values.
        send_job(Q_ZERO, Q_ZERO, Q_ZERO, Q_ZERO, 8'd20, 20'h0DEAD, 0, 8'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_state",       64'(dbg_state),   64'(IDLE));
        check("arst_in_ready",    64'(in_ready),    64'd1);
        check("arst_res_valid",   64'(res_valid),   64'd0);
        check("arst_res_iter",    64'(res_iter),    64'd0);
        check("arst_res_escaped", 64'(res_escaped), 64'd0);
        check("arst_tag_out",     64'(tag_out),     64'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        watch_no_result("arst_no_result", 25);
        send_job(Q_ZERO, Q_ZERO, Q_ZERO, Q_ONE, 8'd7, 20'h00456, 1, 8'd7, 1'b0); wait_idle();

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
